// File: rtl/gf2_128_multiplier_reg.sv
// Registered GF(2^128) multiplier in GCM bit order (bit 127 = x^0).
// Field polynomial x^128 + x^7 + x^2 + x + 1. The product is formed
// combinationally in one cycle and captured into o_data_z when i_valid is high.
module gf2_128_multiplier_reg #(
  parameter int NB_DATA = 128
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data_x,
  input  logic [NB_DATA-1:0] i_data_y,
  input  logic               i_valid,
  output logic [NB_DATA-1:0] o_data_z
);

  // Reduction constant for the reflected polynomial: 0xE1 in the top byte.
  localparam logic [127:0] R_POLY = {8'hE1, 120'h0};

  logic [127:0] product;

  // Shift-and-add multiply.
  // X is scanned from x^0 (bit 127) upward.
  // V is multiplied by x on every step, and the reduction folds in R_POLY.
  function automatic logic [127:0] gf_mult(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ R_POLY;
      else      v = v >> 1;
    end
    return z;
  endfunction

  // Combinational product of the current operands.
  always_comb begin
    product = gf_mult(i_data_x, i_data_y);
  end

  // Output register: reset wins over valid; otherwise hold.
  always_ff @(posedge i_clock) begin
    if (i_reset)      o_data_z <= '0;
    else if (i_valid) o_data_z <= product;
  end

endmodule

// File: tb/tb_gf2_128_multiplier_reg.sv
// Directed-vector bench for gf2_128_multiplier_reg.
// A table of per-cycle records is followed by a walking-one sweep against H.
module tb_gf2_128_multiplier_reg;

  localparam logic [127:0] H     = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C1    = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] P1    = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] XLEN  = 128'h5e2ec746917062882c85b0685353de37;
  localparam logic [127:0] P2    = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] XSUM  = 128'h5da61d88f1c6c11adfad72d122e1204f;
  localparam logic [127:0] PSUM  = 128'hada27c5c47e24154efc0ca8de5e32632;
  localparam logic [127:0] ONE   = 128'h80000000000000000000000000000000;
  localparam logic [127:0] R_POLY = {8'hE1, 120'h0};

  logic         clock;
  logic         reset;
  logic [127:0] data_x;
  logic [127:0] data_y;
  logic         valid;
  logic [127:0] data_z;

  int checks;
  int errors;

  typedef struct {
    string        name;
    logic         rst;
    logic         vld;
    logic [127:0] x;
    logic [127:0] y;
    logic [127:0] exp_z;
  } vec_t;

  vec_t vecs[$];

  gf2_128_multiplier_reg #(.NB_DATA(128)) dut (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_data_x (data_x),
    .i_data_y (data_y),
    .i_valid  (valid),
    .o_data_z (data_z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] exp_z);
    checks++;
    if (data_z !== exp_z) begin
      errors++;
      $display("FAIL %s: got %032h expected %032h", name, data_z, exp_z);
    end
  endtask

  initial begin
    logic [127:0] v;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    valid  = 1'b0;
    data_x = '0;
    data_y = '0;

    vecs.push_back('{"reset",          1'b1, 1'b0, 128'hdeadbeef, 128'h12345678, '0});
    vecs.push_back('{"reset_hold",     1'b0, 1'b0, C1,   H,    '0});
    vecs.push_back('{"gcm_tv2",        1'b0, 1'b1, C1,   H,    P1});
    vecs.push_back('{"ghash_len",      1'b0, 1'b1, XLEN, H,    P2});
    vecs.push_back('{"identity",       1'b0, 1'b1, C1,   ONE,  C1});
    vecs.push_back('{"zero",           1'b0, 1'b1, C1,   '0,   '0});
    vecs.push_back('{"commute",        1'b0, 1'b1, H,    C1,   P1});
    vecs.push_back('{"hold",           1'b0, 1'b0, '1,   '1,   P1});
    vecs.push_back('{"distributive",   1'b0, 1'b1, XSUM, H,    PSUM});
    vecs.push_back('{"reset_priority", 1'b1, 1'b1, C1,   H,    '0});
    vecs.push_back('{"identity_left",  1'b0, 1'b1, ONE,  H,    H});
    vecs.push_back('{"hold2",          1'b0, 1'b0, C1,   C1,   H});

    @(negedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      reset  = vecs[i].rst;
      valid  = vecs[i].vld;
      data_x = vecs[i].x;
      data_y = vecs[i].y;
      @(posedge clock);
      #1;
      check(vecs[i].name, vecs[i].exp_z);
    end

    // Walking one: X = x^k (bit 127-k) times H equals H * x^k.
    // H * x^k is built by repeated multiply-by-x.
    reset = 1'b0;
    valid = 1'b1;
    data_y = H;
    v = H;
    for (int k = 0; k < 128; k++) begin
      data_x = '0;
      data_x[127-k] = 1'b1;
      @(posedge clock);
      #1;
      check($sformatf("walk_%0d", k), v);
      if (v[0]) v = (v >> 1) ^ R_POLY;
      else      v = v >> 1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
